// File: rtl/seq_detector_pkg.sv
// Shared types and defaults for the serial pattern detector family.
// Holds the legacy fixed-pattern state encoding and the programmable detector's control states.
package seq_detector_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_CNT_W   = 8;

    // Legacy fixed 1011 Moore detector states, kept for existing users.
    typedef enum logic [2:0] {
        S_IDLE,
        S_1,
        S_10,
        S_101,
        S_1011
    } state_t;

    typedef enum logic {
        CTRL_UNCFG,
        CTRL_RUN
    } ctrl_state_t;

endpackage

// File: rtl/seq_shift_matcher.sv
// Shift history of qualified bits and compare its newest len bits against the pattern.
// match is combinational for the bit being shifted in this cycle.
module seq_shift_matcher
    import seq_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift,
    input  logic               in_bit,
    input  logic               flush,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < l);
        end
        return m;
    endfunction

    always_comb begin
        hist_n = {history_q[MAX_LEN-2:0], in_bit};
        fill_n = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
        mask   = len_mask(len);
        // fill gate keeps stale or never-written history out of the compare
        match  = shift && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
    end

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        if (flush) begin
            history_d = '0;
            fill_d    = '0;
        end else if (shift) begin
            if (match && !overlap) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = hist_n;
                fill_d    = fill_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control and saturating hit counter.
// Configuration owns the cycle: a cfg_valid beat drops any coincident input bit.
module seq_detector_prog
    import seq_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   det_count,
    input  logic               clear_count,
    output logic               armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_t        state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               cfg_err_q, cfg_err_d;
    logic               seq_detected_q, seq_detected_d;
    logic [CNT_W-1:0]   det_count_q, det_count_d;

    logic cfg_legal;
    logic cfg_load;
    logic shift;
    logic match;

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign cfg_load  = cfg_valid && cfg_legal;
    assign shift     = (state_q == CTRL_RUN) && in_valid && !cfg_valid;

    seq_shift_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .in_bit  (in_bit),
        .flush   (cfg_load),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .match   (match)
    );

    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        len_d          = len_q;
        overlap_d      = overlap_q;
        cfg_err_d      = cfg_valid && !cfg_legal;
        seq_detected_d = match;
        det_count_d    = det_count_q;

        case (state_q)
            CTRL_UNCFG: if (cfg_load) state_d = CTRL_RUN;
            CTRL_RUN:   state_d = CTRL_RUN;
            default:    state_d = CTRL_UNCFG;
        endcase

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
        end

        // clear takes priority over a coincident hit
        if (clear_count) begin
            det_count_d = '0;
        end else if (match && (det_count_q != CNT_MAX)) begin
            det_count_d = det_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CTRL_UNCFG;
            pattern_q      <= '0;
            len_q          <= '0;
            overlap_q      <= 1'b0;
            cfg_err_q      <= 1'b0;
            seq_detected_q <= 1'b0;
            det_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            overlap_q      <= overlap_d;
            cfg_err_q      <= cfg_err_d;
            seq_detected_q <= seq_detected_d;
            det_count_q    <= det_count_d;
        end
    end

    assign cfg_err      = cfg_err_q;
    assign seq_detected = seq_detected_q;
    assign det_count    = det_count_q;
    assign armed        = (state_q == CTRL_RUN);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk;
    logic               rst_n;
    logic               cfg_valid;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               in_valid;
    logic               in_bit;
    logic               seq_detected;
    logic [CNT_W-1:0]   det_count;
    logic               clear_count;
    logic               armed;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .seq_detected (seq_detected),
        .det_count    (det_count),
        .clear_count  (clear_count),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               tag;
        logic             det;
        logic [CNT_W-1:0] cnt;
        logic             err;
        logic             arm;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tag     = 0;

    task automatic cmp(input int t, input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0h expected %0h", t, nm, got, exp);
        end
    endtask

    task automatic push(input logic d, input logic [CNT_W-1:0] c, input logic e, input logic a);
        exp_t x;
        x.tag = tag;
        x.det = d;
        x.cnt = c;
        x.err = e;
        x.arm = a;
        q.push_back(x);
        tag++;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                cmp(x.tag, "seq_detected", {7'd0, seq_detected}, {7'd0, x.det});
                cmp(x.tag, "det_count", {6'd0, det_count}, {6'd0, x.cnt});
                cmp(x.tag, "cfg_err", {7'd0, cfg_err}, {7'd0, x.err});
                cmp(x.tag, "armed", {7'd0, armed}, {7'd0, x.arm});
            end
        end
    end

    task automatic step(input logic cv, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov, input logic iv, input logic b, input logic clr,
                        input logic edet, input logic [CNT_W-1:0] ecnt, input logic eerr, input logic earm);
        cfg_valid   = cv;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = iv;
        in_bit      = b;
        clear_count = clr;
        @(posedge clk);
        #1;
        push(edet, ecnt, eerr, earm);
        cfg_valid   = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        clear_count = 1'b0;
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ov,
                       input logic eerr, input logic earm, input logic [CNT_W-1:0] ecnt);
        step(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0, 1'b0, ecnt, eerr, earm);
    endtask

    task automatic bit_in(input logic b, input logic edet, input logic [CNT_W-1:0] ecnt);
        step(1'b0, '0, '0, 1'b0, 1'b1, b, 1'b0, edet, ecnt, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic [CNT_W-1:0] ecnt, input logic earm);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ecnt, 1'b0, earm);
    endtask

    task automatic clr(input logic earm);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, earm);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must be zero before the next edge
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [MAX_LEN-1:0] long_pat;

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        clear_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(2'd0, 1'b0);

        // 1011 overlapping: hits after bit 4 and bit 7
        cfg(16'h000B, 5'd4, 1'b1, 1'b0, 1'b1, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 2'd1);
        bit_in(1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 2'd1);
        bit_in(1'b1, 1'b1, 2'd2);
        idle(2'd2, 1'b1);
        clr(1'b1);

        // 1011 non-overlapping: history flushed after hit
        cfg(16'h000B, 5'd4, 1'b0, 1'b0, 1'b1, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 2'd1);
        bit_in(1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 2'd1);
        bit_in(1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 2'd1);
        bit_in(1'b1, 1'b1, 2'd2);
        idle(2'd2, 1'b1);
        clr(1'b1);

        // Full-length pattern with two idle cycles between valid bits
        long_pat = 16'hA5C3;
        cfg(long_pat, 5'd16, 1'b1, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < MAX_LEN; i++) begin
            bit_in(long_pat[MAX_LEN-1-i], (i == MAX_LEN - 1), (i == MAX_LEN - 1) ? 2'd1 : 2'd0);
            idle((i == MAX_LEN - 1) ? 2'd1 : 2'd0, 1'b1);
            idle((i == MAX_LEN - 1) ? 2'd1 : 2'd0, 1'b1);
        end
        clr(1'b1);

        // Illegal lengths while unconfigured, then len=1 and saturation
        do_reset();
        cfg(16'h0001, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        idle(2'd0, 1'b0);
        cfg(16'h0001, 5'd17, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        bit_in(1'b1, 1'b1, 2'd1);
        bit_in(1'b1, 1'b1, 2'd2);
        bit_in(1'b1, 1'b1, 2'd3);
        bit_in(1'b1, 1'b1, 2'd3);
        bit_in(1'b1, 1'b1, 2'd3);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        cfg(16'h0001, 5'd0, 1'b0, 1'b1, 1'b1, 2'd0);
        bit_in(1'b1, 1'b1, 2'd1);
        bit_in(1'b0, 1'b0, 2'd1);
        clr(1'b1);

        // Reset mid-stream, reconfigure, no false hit from stale prefix
        cfg(16'h000B, 5'd4, 1'b1, 1'b0, 1'b1, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        do_reset();
        cfg(16'h000B, 5'd4, 1'b1, 1'b0, 1'b1, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 2'd1);
        idle(2'd1, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
